// File: rtl/dmem_ctrl.sv
// Data-memory controller: loads an image from the host, lends the memory to the
// processor while it runs, then streams the output image back to the host.
module dmem_ctrl #(
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned IMG_BYTES = 65536,
   parameter int unsigned OUT_BASE  = 65536,
   parameter int unsigned OUT_BYTES = 16384
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              host_go,
   input  logic              host_in_valid,
   input  logic [7:0]        host_in_data,
   output logic              host_in_ready,
   output logic              host_out_valid,
   output logic [7:0]        host_out_data,
   input  logic              host_out_ready,
   output logic              proc_start,
   input  logic [1:0]        proc_mem,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [7:0]        proc_wdata,
   output logic [7:0]        proc_rdata,
   input  logic              proc_status,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = $clog2(OUT_BYTES) + 1;
   localparam logic [ADDR_W-1:0] LAST_IMG = ADDR_W'(IMG_BYTES - 1);
   localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(OUT_BASE);
   localparam logic [CNT_W-1:0]  LAST_OUT = CNT_W'(OUT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DUMP = 2'b11
   } state_t;

   state_t            state_q;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W-1:0] dump_addr;
   logic [CNT_W-1:0]  out_cnt;
   logic              status_q;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;

   assign state = state_q;

   // Single write port: host during LOAD, processor during RUN.
   always_comb begin
      we    = 1'b0;
      waddr = load_addr;
      wdata = host_in_data;
      if (!RST) begin
         if (state_q == LOAD && host_in_valid) begin
            we = 1'b1;
         end else if (state_q == RUN && proc_mem == 2'b10) begin
            we    = 1'b1;
            waddr = proc_addr;
            wdata = proc_wdata;
         end
      end
   end

   // Memory has no reset so contents survive an aborted job.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q        <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         proc_start     <= 1'b0;
         proc_rdata     <= '0;
         host_in_ready  <= 1'b0;
         host_out_valid <= 1'b0;
         host_out_data  <= '0;
         load_addr      <= '0;
         dump_addr      <= '0;
         out_cnt        <= '0;
         status_q       <= 1'b0;
      end else begin
         done       <= 1'b0;
         proc_start <= 1'b0;
         status_q   <= proc_status;
         case (state_q)
            IDLE: begin
               if (host_go) begin
                  state_q       <= LOAD;
                  busy          <= 1'b1;
                  host_in_ready <= 1'b1;
                  load_addr     <= '0;
               end
            end
            LOAD: begin
               if (host_in_valid) begin
                  load_addr <= load_addr + ADDR_W'(1);
                  if (load_addr == LAST_IMG) begin
                     state_q       <= RUN;
                     host_in_ready <= 1'b0;
                     proc_start    <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (proc_mem == 2'b01) proc_rdata <= mem[proc_addr];
               // The status level seen during the start cycle is stale from the previous program.
               if (!proc_start && proc_status && !status_q) begin
                  state_q   <= DUMP;
                  dump_addr <= OUT_ADDR;
                  out_cnt   <= '0;
               end
            end
            DUMP: begin
               if (!host_out_valid) begin
                  host_out_data  <= mem[dump_addr];
                  host_out_valid <= 1'b1;
                  dump_addr      <= dump_addr + ADDR_W'(1);
               end else if (host_out_ready) begin
                  host_out_valid <= 1'b0;
                  out_cnt        <= out_cnt + CNT_W'(1);
                  if (out_cnt == LAST_OUT) begin
                     state_q <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
